mips_dmem_mmio: RTL and testbench
=================================

# mips_dmem_mmio

Data-side responder for the MIPS core: it receives the core's `memwrite`/`memaddr`/`writedata` and returns `readdata`. It decodes each byte address into a word-addressed RAM region or a memory-mapped I/O window. The I/O window holds a GPIO output register, a free-running cycle counter, and a down-counting timer with a sticky expiry flag and an interrupt. It sits beside the core in the top level, in place of a bare data RAM.

## Interface
Parameters:
- `DEPTH`, 256: RAM depth in 32-bit words; must be a power of two.
- `GPIO_WIDTH`, 8: width of the GPIO output register.
- `MMIO_BASE`, 32'hFFFF_0000: base byte address of the I/O window. The window spans 64 KiB.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `memwrite`  in  1  write strobe from the core.
- `memaddr`  in  DATA_MEM_WIDTH  byte address.
- `writedata`  in  DATA_MEM_WIDTH  store data.
- `readdata`  out  DATA_MEM_WIDTH  load data; combinational from `memaddr`.
- `gpio_out`  out  GPIO_WIDTH  GPIO register value.
- `timer_irq`  out  1  equals `expired & irq_en`.
- `bus_error`  out  1  registered one-cycle pulse on an illegal write.

## Operation
- Address decode:
  - RAM hit when `memaddr < DEPTH*4`. The word index is `memaddr[$clog2(DEPTH)+1:2]`.
  - MMIO hit when `memaddr[31:16] == MMIO_BASE[31:16]`. The register is selected by `memaddr[7:0]`.
  - Anything else is unmapped.
- Reads are combinational and have no side effects. Unmapped addresses and unused MMIO offsets read 0. `addr[1:0]` is ignored on reads.
- A write is illegal when it is misaligned (`addr[1:0] != 0`), unmapped, or targets a read-only register. An illegal write changes no state and raises `bus_error` in the next cycle.
- MMIO registers (offsets):
  - 0x00 GPIO_OUT: read/write, `[GPIO_WIDTH-1:0]`. Upper bits read 0.
  - 0x04 CYCLE_CNT: 32-bit, increments every cycle and wraps from 0xFFFF_FFFF to 0. Any write clears it to 0; this is a legal write.
  - 0x08 TIMER_LOAD: read/write, 32 bits.
  - 0x0C TIMER_CTRL: read/write. bit0 `enable`, bit1 `auto_reload`, bit2 `irq_en`.
  - 0x10 TIMER_STATUS: bit0 `expired`, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x14 TIMER_VALUE: read-only; writing it is illegal.
- Timer state machine:
  - IDLE to RUN when `enable` is 1. On entry, `value <= load`.
  - In RUN, `value` decrements each cycle.
  - In RUN with `value == 0`: set `expired`. If `auto_reload`, `value <= load` and stay in RUN. Otherwise clear `enable` and go to DONE.
  - DONE to IDLE when `enable` is written 0. DONE to RUN when `enable` is written 1, reloading `value`.
  - Writing `enable` = 0 in RUN returns to IDLE and holds `value`.
  - A load of 0 expires on the first RUN cycle.
- Simultaneous events:
  - Hardware setting `expired` and a software clear in the same cycle: the set wins.
  - A CYCLE_CNT write in the same cycle as its increment: the value becomes 0.
  - A TIMER_LOAD write while in RUN: the new value takes effect only at the next reload.
- RAM contents are not reset.

## Timing
- Reset values:
  - `readdata` follows decode; MMIO reads return reset values.
  - `gpio_out` = 0, `timer_irq` = 0, `bus_error` = 0.
  - CYCLE_CNT = 0, LOAD = 0, CTRL = 0, `expired` = 0, `value` = 0, state IDLE.
- Writes commit on the rising edge at which `memwrite` is 1. A read of the same address in the next cycle returns the new data.
- Read-during-write at the same address, same cycle: returns the old data.
- The timer starts on the edge after the `enable` write; `value = load` is visible in the following cycle.
- `expired` and `timer_irq` assert one cycle after the `value == 0` cycle.
- Reset asserted mid-count aborts immediately and asynchronously to the reset values.

## Structure
- The following go in `mips_pkg`:
  - the MMIO offset localparams (`MMIO_GPIO`, `MMIO_CYC`, `MMIO_TLOAD`, `MMIO_TCTRL`, `MMIO_TSTAT`, `MMIO_TVAL`);
  - the CTRL bit-index constants;
  - `typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_DONE} tmr_state_e`.
- One sub-module, `mips_timer`: the state machine, `value`, and `expired`. The top module holds the decode, the RAM array, GPIO, CYCLE_CNT, and the readback mux.

## Test plan
- RAM write/read: write 0xDEAD_BEEF to 0x0000_0010, then read 0x10 → 0xDEAD_BEEF. Then write to 0x0000_0011 → word unchanged, `bus_error` high for exactly 1 cycle.
- GPIO and unmapped access:
  - Write 0x1A5 to MMIO_BASE+0x00 → `gpio_out` = 0xA5; readback = 0xA5.
  - Write 0x1234_0000 → `bus_error` pulse; read returns 0.
- One-shot timer: LOAD = 3, CTRL = 0b101 → `timer_irq` rises 5 cycles after the CTRL write edge. CTRL reads 0b100 and state is DONE. Write 1 to STATUS → irq deasserts the next cycle.
- Auto-reload timer: LOAD = 2, CTRL = 0b011 → `expired` is set every 3 cycles. A STATUS clear in the same cycle as an expiry leaves `expired` = 1.
- Cycle counter: after reset, read CYCLE_CNT at cycle N → N. Write any value → reads 1 one cycle later. Force 0xFFFF_FFFF via hierarchical deposit → wraps to 0.
- Reset mid-operation: assert `rst_n` = 0 during RUN with value = 50 → all outputs and registers return to reset values immediately; TIMER_VALUE reads 0 after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS data-side responder.
// Holds the MMIO register map, TIMER_CTRL/TIMER_STATUS bit positions and the timer state type.
package mips_pkg;

  localparam int DATA_MEM_WIDTH = 32;

  // Byte offsets of the MMIO registers inside the I/O window
  localparam logic [7:0] MMIO_GPIO  = 8'h00;
  localparam logic [7:0] MMIO_CYC   = 8'h04;
  localparam logic [7:0] MMIO_TLOAD = 8'h08;
  localparam logic [7:0] MMIO_TCTRL = 8'h0C;
  localparam logic [7:0] MMIO_TSTAT = 8'h10;
  localparam logic [7:0] MMIO_TVAL  = 8'h14;

  // TIMER_CTRL bit indices
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;
  localparam int CTRL_W  = 3;

  // TIMER_STATUS bit index
  localparam int STAT_EXP = 0;

  typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_DONE} tmr_state_e;

  // Only TIMER_VALUE rejects writes.
  // Unused offsets inside the window accept a write and ignore it.
  function automatic logic mmio_writable(input logic [7:0] off);
    return off != MMIO_TVAL;
  endfunction

endpackage

// File: rtl/mips_timer.sv
// mips_timer: down-counting timer with LOAD/CTRL registers and a sticky expiry flag.
// The state machine follows the CTRL register one edge after software writes it.
module mips_timer
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_load,
  input  logic                      wr_ctrl,
  input  logic                      wr_stat,
  input  logic [DATA_MEM_WIDTH-1:0] wdata,
  output logic [DATA_MEM_WIDTH-1:0] load_q,
  output logic [DATA_MEM_WIDTH-1:0] value,
  output logic [CTRL_W-1:0]         ctrl,
  output logic                      expired,
  output logic                      irq
);

  tmr_state_e                state;
  tmr_state_e                state_d;
  logic [DATA_MEM_WIDTH-1:0] value_d;
  logic                      set_exp;
  logic                      clr_en;

  assign irq = expired & ctrl[CTRL_IE];

  // Next-state, next-value and expiry-event logic
  always_comb begin
    state_d = state;
    value_d = value;
    set_exp = 1'b0;
    clr_en  = 1'b0;
    case (state)
      TMR_IDLE: begin
        if (ctrl[CTRL_EN]) begin
          state_d = TMR_RUN;
          value_d = load_q;
        end
      end
      TMR_RUN: begin
        if (!ctrl[CTRL_EN]) begin
          state_d = TMR_IDLE;
        end else if (value == '0) begin
          set_exp = 1'b1;
          if (ctrl[CTRL_AR]) begin
            value_d = load_q;
          end else begin
            clr_en  = 1'b1;
            state_d = TMR_DONE;
          end
        end else begin
          value_d = value - DATA_MEM_WIDTH'(1);
        end
      end
      TMR_DONE: begin
        if (ctrl[CTRL_EN]) begin
          state_d = TMR_RUN;
          value_d = load_q;
        end else if (wr_ctrl && !wdata[CTRL_EN]) begin
          state_d = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  // State and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TMR_IDLE;
      value <= '0;
    end else begin
      state <= state_d;
      value <= value_d;
    end
  end

  // LOAD register; a write during RUN only matters at the next reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= '0;
    end else if (wr_load) begin
      load_q <= wdata;
    end
  end

  // CTRL register; a software write overrides the one-shot auto-clear of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= wdata[CTRL_W-1:0];
    end else if (clr_en) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // Sticky expiry flag; a hardware set beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired <= 1'b0;
    end else if (set_exp) begin
      expired <= 1'b1;
    end else if (wr_stat && wdata[STAT_EXP]) begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_dmem_mmio.sv
// mips_dmem_mmio: data-side responder for the MIPS core.
// Decodes byte addresses into a word RAM or an MMIO window holding GPIO, a cycle counter and a timer.
// Reads are combinational. Writes commit on the clock edge. Illegal writes pulse bus_error.
module mips_dmem_mmio
  import mips_pkg::*;
#(
  parameter int                        DEPTH      = 256,
  parameter int                        GPIO_WIDTH = 8,
  parameter logic [DATA_MEM_WIDTH-1:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      memwrite,
  input  logic [DATA_MEM_WIDTH-1:0] memaddr,
  input  logic [DATA_MEM_WIDTH-1:0] writedata,
  output logic [DATA_MEM_WIDTH-1:0] readdata,
  output logic [GPIO_WIDTH-1:0]     gpio_out,
  output logic                      timer_irq,
  output logic                      bus_error
);

  localparam int                        AW        = $clog2(DEPTH);
  localparam logic [DATA_MEM_WIDTH-1:0] RAM_BYTES = DATA_MEM_WIDTH'(DEPTH * 4);

  logic                      ram_hit;
  logic                      mmio_hit;
  logic                      aligned;
  logic                      wr_ok;
  logic                      mmio_wr;
  logic [7:0]                reg_off;
  logic [AW-1:0]             word_idx;
  logic                      wr_gpio;
  logic                      wr_cyc;
  logic                      wr_tload;
  logic                      wr_tctrl;
  logic                      wr_tstat;

  logic [DATA_MEM_WIDTH-1:0] ram [DEPTH];
  logic [GPIO_WIDTH-1:0]     gpio_q;
  logic [DATA_MEM_WIDTH-1:0] cyc_cnt;
  logic [DATA_MEM_WIDTH-1:0] tmr_load;
  logic [DATA_MEM_WIDTH-1:0] tmr_value;
  logic [CTRL_W-1:0]         tmr_ctrl;
  logic                      tmr_expired;

  // Address decode; the low two address bits are ignored when selecting a register
  assign ram_hit  = memaddr < RAM_BYTES;
  assign mmio_hit = memaddr[31:16] == MMIO_BASE[31:16];
  assign aligned  = memaddr[1:0] == 2'b00;
  assign reg_off  = {memaddr[7:2], 2'b00};
  assign word_idx = memaddr[AW+1:2];

  // A write is legal only when aligned and aimed at RAM or a writable MMIO register
  assign wr_ok    = memwrite && aligned && (ram_hit || (mmio_hit && mmio_writable(reg_off)));
  assign mmio_wr  = wr_ok && mmio_hit;
  assign wr_gpio  = mmio_wr && (reg_off == MMIO_GPIO);
  assign wr_cyc   = mmio_wr && (reg_off == MMIO_CYC);
  assign wr_tload = mmio_wr && (reg_off == MMIO_TLOAD);
  assign wr_tctrl = mmio_wr && (reg_off == MMIO_TCTRL);
  assign wr_tstat = mmio_wr && (reg_off == MMIO_TSTAT);

  assign gpio_out = gpio_q;

  // Word RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) begin
      ram[word_idx] <= writedata;
    end
  end

  // GPIO output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q <= '0;
    end else if (wr_gpio) begin
      gpio_q <= writedata[GPIO_WIDTH-1:0];
    end
  end

  // Free-running cycle counter; any write forces it to zero instead of incrementing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (wr_cyc) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + DATA_MEM_WIDTH'(1);
    end
  end

  // One-cycle pulse flagging the illegal write of the previous cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_error <= 1'b0;
    end else begin
      bus_error <= memwrite && !wr_ok;
    end
  end

  mips_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_load (wr_tload),
    .wr_ctrl (wr_tctrl),
    .wr_stat (wr_tstat),
    .wdata   (writedata),
    .load_q  (tmr_load),
    .value   (tmr_value),
    .ctrl    (tmr_ctrl),
    .expired (tmr_expired),
    .irq     (timer_irq)
  );

  // Combinational readback; unmapped space and unused offsets read zero
  always_comb begin
    readdata = '0;
    if (ram_hit) begin
      readdata = ram[word_idx];
    end else if (mmio_hit) begin
      case (reg_off)
        MMIO_GPIO:  readdata = DATA_MEM_WIDTH'(gpio_q);
        MMIO_CYC:   readdata = cyc_cnt;
        MMIO_TLOAD: readdata = tmr_load;
        MMIO_TCTRL: readdata = DATA_MEM_WIDTH'(tmr_ctrl);
        MMIO_TSTAT: readdata = DATA_MEM_WIDTH'(tmr_expired);
        MMIO_TVAL:  readdata = tmr_value;
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// tb_mips_dmem_mmio: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mips_dmem_mmio;
  import mips_pkg::*;

  localparam int          DEPTH      = 256;
  localparam int          GPIO_WIDTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO     = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_CYC      = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_TLOAD    = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_TCTRL    = MMIO_BASE + 32'h0C;
  localparam logic [31:0] A_TSTAT    = MMIO_BASE + 32'h10;
  localparam logic [31:0] A_TVAL     = MMIO_BASE + 32'h14;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  memwrite  = 1'b0;
  logic [31:0]           memaddr   = '0;
  logic [31:0]           writedata = '0;
  logic [31:0]           readdata;
  logic [GPIO_WIDTH-1:0] gpio_out;
  logic                  timer_irq;
  logic                  bus_error;

  mips_dmem_mmio #(
    .DEPTH      (DEPTH),
    .GPIO_WIDTH (GPIO_WIDTH),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .memwrite  (memwrite),
    .memaddr   (memaddr),
    .writedata (writedata),
    .readdata  (readdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]           m_ram [int unsigned];
  logic [GPIO_WIDTH-1:0] m_gpio;
  logic [31:0]           m_cyc;
  logic [31:0]           m_load;
  logic [31:0]           m_val;
  logic [2:0]            m_ctrl;
  logic                  m_exp;
  logic                  m_berr;
  bit                    m_counting;

  task automatic model_reset();
    m_gpio = '0; m_cyc = '0; m_load = '0; m_val = '0;
    m_ctrl = '0; m_exp = 1'b0; m_berr = 1'b0; m_counting = 1'b0;
  endtask

  // One clock edge of the specified behaviour, given the inputs held during the cycle
  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  off;
    logic [31:0] old_load;
    logic [2:0]  old_ctrl;
    bit          is_ram, is_io, legal, fired;
    is_ram   = (a < 32'(DEPTH * 4));
    is_io    = (a[31:16] == MMIO_BASE[31:16]);
    off      = a[7:0];
    legal    = we && (a[1:0] == 2'b00) && (is_ram || (is_io && off != 8'h14));
    m_berr   = we && !legal;
    old_load = m_load;
    old_ctrl = m_ctrl;
    fired    = 1'b0;
    // timer follows the settings held before this edge
    if (m_counting) begin
      if (!old_ctrl[0]) begin
        m_counting = 1'b0;
      end else if (m_val == 0) begin
        fired = 1'b1;
        if (old_ctrl[1]) m_val = old_load;
        else begin
          m_counting = 1'b0;
          m_ctrl[0]  = 1'b0;
        end
      end else begin
        m_val = m_val - 1;
      end
    end else if (old_ctrl[0]) begin
      m_counting = 1'b1;
      m_val      = old_load;
    end
    m_cyc = (legal && is_io && off == 8'h04) ? 32'd0 : m_cyc + 32'd1;
    if (legal && is_ram) m_ram[a >> 2] = d;
    if (legal && is_io) begin
      case (off)
        8'h00: m_gpio = d[GPIO_WIDTH-1:0];
        8'h08: m_load = d;
        8'h0C: m_ctrl = d[2:0];
        8'h10: if (d[0]) m_exp = 1'b0;
        default: ;
      endcase
    end
    if (fired) m_exp = 1'b1;
  endtask

  // Expected readdata; returns 0 when the RAM word was never written
  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    int unsigned key;
    v = '0;
    if (a < 32'(DEPTH * 4)) begin
      key = a >> 2;
      if (m_ram.exists(key)) begin
        v = m_ram[key];
        return 1'b1;
      end
      return 1'b0;
    end
    if (a[31:16] == MMIO_BASE[31:16]) begin
      case ({a[7:2], 2'b00})
        8'h00: v = 32'(m_gpio);
        8'h04: v = m_cyc;
        8'h08: v = m_load;
        8'h0C: v = 32'(m_ctrl);
        8'h10: v = 32'(m_exp);
        8'h14: v = m_val;
        default: v = '0;
      endcase
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step(memwrite, memaddr, writedata);
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (rst_n) begin
      if (model_read(memaddr, exp_rd)) check("readdata", readdata, exp_rd);
      check("gpio_out", 32'(gpio_out), 32'(m_gpio));
      check("timer_irq", 32'(timer_irq), 32'(m_exp & m_ctrl[2]));
      check("bus_error", 32'(bus_error), 32'(m_berr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    memaddr   = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, r;
    logic [7:0]  off8;
    logic [1:0]  mis;
    int unsigned kind;

    model_reset();

    // reset values while rst_n is held low
    #12;
    memaddr = A_CYC;   #1 check("rst_cyc", readdata, 32'd0);
    memaddr = A_TVAL;  #1 check("rst_tval", readdata, 32'd0);
    memaddr = A_TCTRL; #1 check("rst_tctrl", readdata, 32'd0);
    check("rst_gpio", 32'(gpio_out), 32'd0);
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_berr", 32'(bus_error), 32'd0);

    @(posedge clk); #1;
    rst_n   = 1'b1;
    memaddr = A_CYC;
    // cycle counter equals the number of edges since reset release
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cyc_after_reset", readdata, 32'(k));
      step();
    end

    // RAM write/read and misaligned store
    wr(32'h10, 32'hDEAD_BEEF);
    memaddr = 32'h10;
    @(negedge clk); check("ram_rd", readdata, 32'hDEAD_BEEF); #1;
    wr(32'h11, 32'h0BAD_F00D);
    memaddr = 32'h10;
    @(negedge clk);
    check("misalign_berr", 32'(bus_error), 32'd1);
    check("misalign_word", readdata, 32'hDEAD_BEEF);
    #1; step();
    @(negedge clk); check("misalign_berr_end", 32'(bus_error), 32'd0); #1;

    // GPIO and unmapped store
    wr(A_GPIO, 32'h1A5);
    memaddr = A_GPIO;
    @(negedge clk);
    check("gpio_out_lit", 32'(gpio_out), 32'hA5);
    check("gpio_rd_lit", readdata, 32'hA5);
    #1;
    wr(32'h1234_0000, 32'h55);
    memaddr = 32'h1234_0000;
    @(negedge clk);
    check("unmapped_berr", 32'(bus_error), 32'd1);
    check("unmapped_rd", readdata, 32'd0);
    #1;

    // cycle counter write and wrap
    wr(A_CYC, 32'h1357);
    memaddr = A_CYC;
    @(negedge clk); check("cyc_cleared", readdata, 32'd0); #1;
    step();
    @(negedge clk); check("cyc_after_clear", readdata, 32'd1); #1;
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #1 release dut.cyc_cnt;
    #1 check("cyc_forced", readdata, 32'hFFFF_FFFF);
    step();
    @(negedge clk); check("cyc_wrap", readdata, 32'd0); #1;

    // one-shot timer: LOAD=3, CTRL=enable|irq_en
    wr(A_TLOAD, 32'd3);
    wr(A_TCTRL, 32'b101);
    memaddr = A_TVAL;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      check("oneshot_irq", 32'(timer_irq), 32'(i == 5));
      check("oneshot_val", readdata, (i == 0 || i >= 4) ? 32'd0 : 32'(4 - i));
      if (i < 5) step();
    end
    #1 memaddr = A_TCTRL;
    #1 check("oneshot_ctrl", readdata, 32'b100);
    check("oneshot_state", 32'(dut.u_timer.state), 32'(TMR_DONE));
    wr(A_TSTAT, 32'd1);
    @(negedge clk); check("oneshot_irq_clear", 32'(timer_irq), 32'd0); #1;

    // auto-reload timer: LOAD=2, CTRL=enable|auto_reload; clears at edges 5 and 10
    wr(A_TCTRL, 32'd0);
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'b011);
    for (int i = 1; i <= 11; i++) begin
      memaddr   = A_TSTAT;
      writedata = 32'd1;
      memwrite  = (i == 5 || i == 10);
      step();
      memwrite  = 1'b0;
      @(negedge clk);
      check("autoreload_expired", readdata, 32'(i == 4 || i >= 7));
      #1;
    end
    wr(A_TCTRL, 32'd0);
    wr(A_TSTAT, 32'd1);

    // asynchronous reset in the middle of a count
    wr(A_TLOAD, 32'd60);
    wr(A_TCTRL, 32'b101);
    memaddr = A_TVAL;
    repeat (11) step();
    @(negedge clk); check("run_val_50", readdata, 32'd50);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gpio", 32'(gpio_out), 32'd0);
    check("midrst_irq", 32'(timer_irq), 32'd0);
    check("midrst_berr", 32'(bus_error), 32'd0);
    check("midrst_tval", readdata, 32'd0);
    memaddr = A_TCTRL; #1 check("midrst_tctrl", readdata, 32'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    memaddr = A_TVAL;
    @(negedge clk); check("postrst_tval", readdata, 32'd0); #1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r    = $urandom;
      kind = $urandom_range(0, 9);
      mis  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      off8 = 8'($urandom_range(0, 7) * 4);
      case (kind)
        0, 1, 2: a = (32'($urandom_range(0, 15)) << 2) | 32'(mis);
        3:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
        4, 5, 6, 7: begin
          a = MMIO_BASE | 32'(off8) | 32'(mis);
          if ($urandom_range(0, 3) == 0) a = a | (32'(r[15:8]) << 8);
        end
        8:       a = r;
        default: a = {16'hFFFE, r[15:0]};
      endcase
      if (kind >= 4 && kind <= 7 && off8 == 8'h08) d = 32'($urandom_range(0, 6));
      else                                         d = $urandom;
      memaddr   = a;
      writedata = d;
      memwrite  = ($urandom_range(0, 99) < 40);
      step();
    end
    memwrite = 1'b0;
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
